// File: rtl/ysyx_24100029_btb_update.sv
// Branch resolution and BTB write side: detects mispredictions, pulses a
// registered redirect, queues BTB refills and drains one per cycle.
module ysyx_24100029_btb_update #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [31:0]          ex_pc,
  input  logic [1:0]           ex_br_type,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic                 ex_pred_hit,
  input  logic [31:0]          ex_pred_npc,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 btb_commit,
  output logic [31:0]          btb_commit_pc,
  output logic [1:0]           btb_commit_pc_type,
  output logic [31:0]          btb_commit_npc,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);
  // Handshake: a result transfers on a rising edge where ex_valid && ex_ready;
  // ex_ready depends only on reset and the registered fill level.
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  pc_type;
    logic [31:0] npc;
  } entry_t;

  entry_t mem [DEPTH];
  entry_t new_entry;
  entry_t head;

  logic [PW-1:0] rd_ptr, wr_ptr, last_ptr, wr_idx;
  logic [PW:0]   count;
  logic          acc, tk, mis, upd, coalesce, push, pop;
  logic [31:0]   seq_pc, act, prd;

  always_comb begin
    ex_ready  = !reset && (count != FULL);
    acc       = ex_valid && ex_ready;
    tk        = (ex_br_type[1]) || (ex_br_type == 2'b01 && ex_taken);
    seq_pc    = ex_pc + 32'd4;
    act       = tk ? ex_target : seq_pc;
    prd       = ex_pred_hit ? ex_pred_npc : seq_pc;
    mis       = acc && (act != prd);
    upd       = acc && tk && (!ex_pred_hit || ex_pred_npc != ex_target);
    last_ptr  = wr_ptr - 1'b1;
    // A lone entry is being popped this edge, so it cannot absorb the update.
    coalesce  = upd && (count > ONE) && (mem[last_ptr].pc == ex_pc);
    push      = upd && !coalesce;
    pop       = (count != '0);
    wr_idx    = coalesce ? last_ptr : wr_ptr;
    new_entry = '{pc: ex_pc, pc_type: ex_br_type, npc: ex_target};
    head      = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (upd) mem[wr_idx] <= new_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      btb_commit         <= 1'b0;
      btb_commit_pc      <= '0;
      btb_commit_pc_type <= '0;
      btb_commit_npc     <= '0;
      redirect_valid     <= 1'b0;
      redirect_pc        <= '0;
      branch_cnt         <= '0;
      mispred_cnt        <= '0;
    end else begin
      btb_commit <= pop;
      if (pop) begin
        btb_commit_pc      <= head.pc;
        btb_commit_pc_type <= head.pc_type;
        btb_commit_npc     <= head.npc;
        rd_ptr             <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase

      redirect_valid <= mis;
      if (mis) redirect_pc <= act;

      if (acc && ex_br_type != 2'b00 && branch_cnt != {CNT_WIDTH{1'b1}})
        branch_cnt <= branch_cnt + 1'b1;
      if (mis && mispred_cnt != {CNT_WIDTH{1'b1}})
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_24100029_btb_update.sv
// Bench for the BTB update unit: directed scenarios plus random traffic,
// checked against a queue-based model of the resolution rules.
module tb_ysyx_24100029_btb_update;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [31:0]   ex_pc = '0;
  logic [1:0]    ex_br_type = '0;
  logic          ex_taken = 1'b0;
  logic [31:0]   ex_target = '0;
  logic          ex_pred_hit = 1'b0;
  logic [31:0]   ex_pred_npc = '0;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          btb_commit;
  logic [31:0]   btb_commit_pc;
  logic [1:0]    btb_commit_pc_type;
  logic [31:0]   btb_commit_npc;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispred_cnt;

  ysyx_24100029_btb_update #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_br_type(ex_br_type), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_hit(ex_pred_hit), .ex_pred_npc(ex_pred_npc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_commit(btb_commit), .btb_commit_pc(btb_commit_pc),
    .btb_commit_pc_type(btb_commit_pc_type), .btb_commit_npc(btb_commit_npc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: pending refills, expected pulses, saturating counters
  logic [65:0]   m_fifo[$];
  logic [65:0]   exp_q[$];
  logic [31:0]   exp_redir_q[$];
  logic [CW-1:0] m_br = '0;
  logic [CW-1:0] m_mis = '0;

  always @(posedge clock) begin
    logic        m_acc, m_tk, m_mispred, m_upd, m_merge;
    logic [31:0] m_act, m_prd;
    logic [65:0] ent;
    if (reset) begin
      m_fifo.delete();
      m_br  = '0;
      m_mis = '0;
    end else begin
      m_acc     = ex_valid && (m_fifo.size() != DEPTH);
      m_tk      = (ex_br_type == 2'b10) || (ex_br_type == 2'b11) || (ex_br_type == 2'b01 && ex_taken);
      m_act     = m_tk ? ex_target : ex_pc + 32'd4;
      m_prd     = ex_pred_hit ? ex_pred_npc : ex_pc + 32'd4;
      m_mispred = m_acc && (m_act != m_prd);
      m_upd     = m_acc && m_tk && !(ex_pred_hit && ex_pred_npc == ex_target);
      m_merge   = m_upd && m_fifo.size() >= 2 && m_fifo[m_fifo.size()-1][65:34] == ex_pc;
      ent       = {ex_pc, ex_br_type, ex_target};
      if (m_fifo.size() != 0) exp_q.push_back(m_fifo.pop_front());
      if (m_merge) m_fifo[m_fifo.size()-1] = ent;
      else if (m_upd) m_fifo.push_back(ent);
      if (m_mispred) exp_redir_q.push_back(m_act);
      if (m_acc && ex_br_type != 2'b00 && m_br != CMAX) m_br = m_br + 1'b1;
      if (m_mispred && m_mis != CMAX) m_mis = m_mis + 1'b1;
    end
  end

  // Monitor / scoreboard
  always @(negedge clock) begin
    logic [65:0] e;
    if (mon_en) begin
      chk("ex_ready", 66'(ex_ready), 66'(!reset && m_fifo.size() != DEPTH));
      chk("branch_cnt", 66'(branch_cnt), 66'(m_br));
      chk("mispred_cnt", 66'(mispred_cnt), 66'(m_mis));
      chk("btb_commit", 66'(btb_commit), 66'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (btb_commit) chk("commit_entry", {btb_commit_pc, btb_commit_pc_type, btb_commit_npc}, e);
      end
      chk("redirect_valid", 66'(redirect_valid), 66'(exp_redir_q.size() != 0));
      if (exp_redir_q.size() != 0) begin
        e = 66'(exp_redir_q.pop_front());
        if (redirect_valid) chk("redirect_pc", 66'(redirect_pc), e);
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] t,
                       input logic tkn, input logic [31:0] tgt,
                       input logic hit, input logic [31:0] npc);
    @(posedge clock);
    #1;
    ex_valid = v; ex_pc = pc; ex_br_type = t; ex_taken = tkn;
    ex_target = tgt; ex_pred_hit = hit; ex_pred_npc = npc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 2'b00, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clock);
    #1 reset = 1'b1;
    ex_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h8000_0000; pcs[1] = 32'h8000_0010;
    pcs[2] = 32'h600;       pcs[3] = 32'hFFFF_FFFC;

    @(posedge clock);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    idle(1);

    // Cold jal, correct hit, not-taken, stale hit on non-branch
    drive(1'b1, 32'h8000_0000, 2'b10, 1'b0, 32'h8000_0100, 1'b0, '0);
    idle(3);
    drive(1'b1, 32'h100, 2'b01, 1'b1, 32'h200, 1'b1, 32'h200);
    drive(1'b1, 32'h104, 2'b01, 1'b0, 32'h300, 1'b0, '0);
    drive(1'b1, 32'h1000, 2'b00, 1'b0, '0, 1'b1, 32'h2000);
    idle(3);

    // Back-to-back distinct taken misses
    for (int i = 0; i < 6; i++)
      drive(1'b1, 32'h400 + 32'(i*4), 2'b11, 1'b1, 32'h5000 + 32'(i*16), 1'b0, '0);
    idle(3);

    // Same-pc jalr pair behind an earlier entry
    drive(1'b1, 32'h500, 2'b10, 1'b0, 32'h900, 1'b0, '0);
    drive(1'b1, 32'h600, 2'b11, 1'b1, 32'hA0, 1'b0, '0);
    drive(1'b1, 32'h600, 2'b11, 1'b1, 32'hB0, 1'b0, '0);
    idle(3);

    // Reset with traffic in flight
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h700 + 32'(i*4), 2'b10, 1'b0, 32'h7700, 1'b0, '0);
    do_reset(1);
    idle(2);

    // Counter saturation
    for (int i = 0; i < 20; i++)
      drive(1'b1, 32'h2000 + 32'(i*4), 2'b10, 1'b0, 32'h3000, 1'b0, '0);
    idle(2);
    @(negedge clock);
    chk("mispred_sat", 66'(mispred_cnt), 66'(15));
    do_reset(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc, tgt;
      logic hit;
      pc  = pcs[$urandom_range(0, 3)] + 32'($urandom_range(0, 3) * 4);
      tgt = 32'($urandom_range(0, 15)) << 4;
      hit = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 3) != 0), pc, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), tgt, hit,
            ($urandom_range(0, 1) != 0) ? tgt : pc + 32'd4);
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end
    idle(6);
    @(negedge clock);
    chk("drained_commits", 66'(exp_q.size()), 66'(0));
    chk("drained_redirects", 66'(exp_redir_q.size()), 66'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
